// File: rtl/pipeline_latealu.sv
// Late-ALU execute stage: single-cycle srl/sra, iterative 32x32 multiply and
// the HI/LO registers, with a hazard stall toward the ALU stage.
module pipeline_latealu #(
    parameter int unsigned MULT_STEP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        latealu_enable,
    input  logic [5:0]  latealu_op,
    input  logic [31:0] latealu_a0,
    input  logic [31:0] latealu_a1,
    input  logic [4:0]  rd_index_in,
    input  logic [31:0] rd_value_in,
    input  logic        hilo_read,
    output logic [4:0]  rd_index_out,
    output logic [31:0] rd_value_out,
    output logic [31:0] mult_hi,
    output logic [31:0] mult_lo,
    output logic        busy,
    output logic        stall
);
    localparam int unsigned ITER  = 32 / MULT_STEP;
    localparam int unsigned CNT_W = 6;

    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MULT  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000101;
    localparam logic [5:0] OP_MTLO  = 6'b000110;
    localparam logic [5:0] OP_MULTU = 6'b000111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      mcand_q, mcand_d;
    logic [31:0]      mplier_q, mplier_d;
    logic [63:0]      acc_q, acc_d;
    logic             sign_q, sign_d;
    logic [31:0]      hi_d, lo_d;
    logic [4:0]       rd_index_d;
    logic [31:0]      rd_value_d;
    logic             busy_d;

    logic             is_hilo_op;
    logic             accept;
    logic             mult_signed;
    logic [4:0]       shamt;
    logic [31:0]      mag_a0, mag_a1;
    logic [63:0]      partial, result;

    // Decode and operand conditioning
    assign is_hilo_op  = (latealu_op == OP_MULT) || (latealu_op == OP_MULTU) ||
                         (latealu_op == OP_MTHI) || (latealu_op == OP_MTLO);
    assign stall       = busy & (hilo_read | (latealu_enable & is_hilo_op));
    assign accept      = latealu_enable & ~stall;
    assign mult_signed = (latealu_op == OP_MULT);
    assign shamt       = latealu_a1[4:0];
    assign mag_a0      = (mult_signed && latealu_a0[31]) ? -latealu_a0 : latealu_a0;
    assign mag_a1      = (mult_signed && latealu_a1[31]) ? -latealu_a1 : latealu_a1;
    assign partial     = mcand_q * 64'(mplier_q[MULT_STEP-1:0]);
    assign result      = sign_q ? -acc_q : acc_q;

    // Next-state, writeback and HI/LO update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        sign_d     = sign_q;
        hi_d       = mult_hi;
        lo_d       = mult_lo;
        rd_index_d = rd_index_in;
        rd_value_d = rd_value_in;

        if (stall) begin
            rd_index_d = 5'd0;
        end else if (accept) begin
            case (latealu_op)
                OP_SRL:  rd_value_d = latealu_a0 >> shamt;
                OP_SRA:  rd_value_d = 32'($signed(latealu_a0) >>> shamt);
                OP_MTHI: begin
                    rd_index_d = 5'd0;
                    hi_d       = latealu_a0;
                end
                OP_MTLO: begin
                    rd_index_d = 5'd0;
                    lo_d       = latealu_a0;
                end
                OP_MULT, OP_MULTU: rd_index_d = 5'd0;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (accept && (latealu_op == OP_MULT || latealu_op == OP_MULTU)) begin
                    mcand_d  = {32'd0, mag_a0};
                    mplier_d = mag_a1;
                    acc_d    = 64'd0;
                    sign_d   = mult_signed & (latealu_a0[31] ^ latealu_a1[31]);
                    cnt_d    = CNT_W'(ITER);
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << MULT_STEP;
                mplier_d = mplier_q >> MULT_STEP;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = result[63:32];
                lo_d    = result[31:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            sign_q       <= 1'b0;
            mult_hi      <= '0;
            mult_lo      <= '0;
            rd_index_out <= '0;
            rd_value_out <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            sign_q       <= sign_d;
            mult_hi      <= hi_d;
            mult_lo      <= lo_d;
            rd_index_out <= rd_index_d;
            rd_value_out <= rd_value_d;
            busy         <= busy_d;
        end
    end
endmodule

// File: tb/tb_pipeline_latealu.sv
// Scoreboard bench for pipeline_latealu: a cycle-level reference model queues
// expected outputs, a negedge monitor pops and compares them.
module tb_pipeline_latealu;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MULT  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000101;
    localparam logic [5:0] OP_MTLO  = 6'b000110;
    localparam logic [5:0] OP_MULTU = 6'b000111;
    localparam int         ITER2    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        latealu_enable;
    logic [5:0]  latealu_op;
    logic [31:0] latealu_a0, latealu_a1;
    logic [4:0]  rd_index_in;
    logic [31:0] rd_value_in;
    logic        hilo_read;

    logic [4:0]  idx1, idx2, idx4;
    logic [31:0] val1, val2, val4, hi1, hi2, hi4, lo1, lo2, lo4;
    logic        busy1, busy2, busy4, stall1, stall2, stall4;

    always #5 clk = ~clk;

    pipeline_latealu #(.MULT_STEP(2)) u_s2 (
        .clk(clk), .rst(rst), .latealu_enable(latealu_enable), .latealu_op(latealu_op),
        .latealu_a0(latealu_a0), .latealu_a1(latealu_a1), .rd_index_in(rd_index_in),
        .rd_value_in(rd_value_in), .hilo_read(hilo_read), .rd_index_out(idx2),
        .rd_value_out(val2), .mult_hi(hi2), .mult_lo(lo2), .busy(busy2), .stall(stall2));
    pipeline_latealu #(.MULT_STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .latealu_enable(latealu_enable), .latealu_op(latealu_op),
        .latealu_a0(latealu_a0), .latealu_a1(latealu_a1), .rd_index_in(rd_index_in),
        .rd_value_in(rd_value_in), .hilo_read(hilo_read), .rd_index_out(idx1),
        .rd_value_out(val1), .mult_hi(hi1), .mult_lo(lo1), .busy(busy1), .stall(stall1));
    pipeline_latealu #(.MULT_STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .latealu_enable(latealu_enable), .latealu_op(latealu_op),
        .latealu_a0(latealu_a0), .latealu_a1(latealu_a1), .rd_index_in(rd_index_in),
        .rd_value_in(rd_value_in), .hilo_read(hilo_read), .rd_index_out(idx4),
        .rd_value_out(val4), .mult_hi(hi4), .mult_lo(lo4), .busy(busy4), .stall(stall4));

    typedef struct {
        int          cyc;
        logic [4:0]  idx;
        logic [31:0] val;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
    } out_t;
    typedef struct {
        int   cyc;
        logic stall;
    } stl_t;

    out_t out_q[$];
    stl_t stl_q[$];
    out_t mo;
    stl_t ms;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state: HI/LO, cycles of busy left, pending product
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic [63:0] m_res;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due in this cycle
    always @(negedge clk) begin
        while (stl_q.size() > 0 && stl_q[0].cyc <= cyc) begin
            ms = stl_q.pop_front();
            checks++;
            if (ms.cyc != cyc || stall2 !== ms.stall) begin
                errors++;
                $display("FAIL stall cyc=%0d due=%0d got=%b exp=%b", cyc, ms.cyc, stall2, ms.stall);
            end
        end
        while (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
            mo = out_q.pop_front();
            checks++;
            if (mo.cyc != cyc || idx2 !== mo.idx || val2 !== mo.val || hi2 !== mo.hi ||
                lo2 !== mo.lo || busy2 !== mo.busy) begin
                errors++;
                $display("FAIL out cyc=%0d due=%0d got idx=%0d val=%h hi=%h lo=%h busy=%b exp idx=%0d val=%h hi=%h lo=%h busy=%b",
                         cyc, mo.cyc, idx2, val2, hi2, lo2, busy2, mo.idx, mo.val, mo.hi, mo.lo, mo.busy);
            end
        end
    end

    function automatic logic is_hl(input logic [5:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_MTHI || op == OP_MTLO;
    endfunction

    function automatic logic [63:0] prod(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (op == OP_MULT) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One clock of stimulus; model predicts stall now and outputs after the edge
    task automatic step(input logic en, input logic [5:0] op, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [4:0] idx, input logic [31:0] val,
                        input logic hr, output logic stalled);
        logic       stl, acc;
        logic [4:0] e_idx;
        logic [31:0] e_val;
        out_t       o;
        stl_t       s;
        latealu_enable = en; latealu_op = op; latealu_a0 = a0; latealu_a1 = a1;
        rd_index_in = idx; rd_value_in = val; hilo_read = hr;
        stl = (m_left > 0) && (hr || (en && is_hl(op)));
        acc = en && !stl;
        s.cyc = cyc; s.stall = stl;
        stl_q.push_back(s);
        e_idx = stl ? 5'd0 : idx;
        e_val = val;
        if (m_left == 1) {m_hi, m_lo} = m_res;
        if (m_left > 0) m_left--;
        if (acc) begin
            case (op)
                OP_SRL: e_val = a0 >> a1[4:0];
                OP_SRA: e_val = 32'($signed(a0) >>> a1[4:0]);
                OP_MTHI: begin e_idx = 5'd0; m_hi = a0; end
                OP_MTLO: begin e_idx = 5'd0; m_lo = a0; end
                OP_MULT, OP_MULTU: begin
                    e_idx  = 5'd0;
                    m_res  = prod(op, a0, a1);
                    m_left = ITER2 + 1;
                end
                default: ;
            endcase
        end
        o.cyc = cyc + 1; o.idx = e_idx; o.val = e_val; o.hi = m_hi; o.lo = m_lo; o.busy = (m_left > 0);
        out_q.push_back(o);
        @(posedge clk);
        #1;
        stalled = stl;
    endtask

    // Re-present a request until it is accepted, as upstream would
    task automatic issue(input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [4:0] idx, input logic [31:0] val, input logic hr);
        logic st;
        int   n = 0;
        do begin
            step(1'b1, op, a0, a1, idx, val, hr, st);
            n++;
        end while (st && n < 100);
        if (st) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout op=%b still stalled after %0d cycles", op, n);
        end
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++)
            step(1'b0, 6'd0, 32'd0, 32'd0, 5'($urandom), $urandom, 1'b0, st);
    endtask

    // Async reset at the current cycle; queued expectation for now becomes the reset state
    task automatic reset_pulse();
        out_t o;
        stl_t s;
        if (out_q.size() > 0 && out_q[$].cyc == cyc) void'(out_q.pop_back());
        latealu_enable = 1'b0; hilo_read = 1'b0; latealu_op = 6'd0;
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_left = 0;
        o.idx = '0; o.val = '0; o.hi = '0; o.lo = '0; o.busy = 1'b0;
        o.cyc = cyc;     out_q.push_back(o);
        o.cyc = cyc + 1; out_q.push_back(o);
        s.cyc = cyc; s.stall = 1'b0; stl_q.push_back(s);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Run one mult on all three step widths and check latency and result
    task automatic lat_case(input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c1 = 0, c2 = 0, c4 = 0;
        logic st;
        step(1'b1, op, a0, a1, 5'd9, 32'h55, 1'b0, st);
        chk("accept_idx", 32'(idx2), 32'd0);
        for (int i = 0; i < 40; i++) begin
            c1 += int'(busy1); c2 += int'(busy2); c4 += int'(busy4);
            step(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, st);
        end
        chk("lat_step1", 32'(c1), 32'd33);
        chk("lat_step2", 32'(c2), 32'd17);
        chk("lat_step4", 32'(c4), 32'd9);
        chk("hi_step1", hi1, exp_hi); chk("lo_step1", lo1, exp_lo);
        chk("hi_step2", hi2, exp_hi); chk("lo_step2", lo2, exp_lo);
        chk("hi_step4", hi4, exp_hi); chk("lo_step4", lo4, exp_lo);
    endtask

    logic [5:0] ops [8] = '{OP_SRL, OP_SRA, OP_MULT, OP_MTHI, OP_MTLO, OP_MULTU, 6'd0, 6'h3f};

    initial begin
        logic        st;
        out_t        o;
        stl_t        s;
        logic [5:0]  op;
        logic [31:0] a0, a1;
        rst = 1'b0;
        latealu_enable = 1'b0; latealu_op = '0; latealu_a0 = '0; latealu_a1 = '0;
        rd_index_in = '0; rd_value_in = '0; hilo_read = 1'b0;
        m_hi = '0; m_lo = '0; m_left = 0; m_res = '0;
        repeat (2) @(posedge clk);
        #1;
        o.cyc = cyc; o.idx = '0; o.val = '0; o.hi = '0; o.lo = '0; o.busy = 1'b0;
        out_q.push_back(o);
        s.cyc = cyc; s.stall = 1'b0; stl_q.push_back(s);
        @(posedge clk);
        #1;
        rst = 1'b1;

        lat_case(OP_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB);
        lat_case(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        lat_case(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

        step(1'b1, OP_SRL, 32'h80000000, 32'd4, 5'd3, 32'd0, 1'b0, st);
        chk("srl", val2, 32'h08000000);
        step(1'b1, OP_SRA, 32'h80000000, 32'd4, 5'd3, 32'd0, 1'b0, st);
        chk("sra", val2, 32'hF8000000);
        step(1'b1, OP_SRL, 32'h80000000, 32'h24, 5'd3, 32'd0, 1'b0, st);
        chk("srl_amt5", val2, 32'h08000000);

        // Hazards: shift during busy, stalled mthi, then mfhi
        issue(OP_MULT, 32'd1234, 32'd5678, 5'd4, 32'd1, 1'b0);
        issue(OP_SRL, 32'hF0F0F0F0, 32'd8, 5'd6, 32'd2, 1'b0);
        issue(OP_MTHI, 32'h1234, 32'd0, 5'd7, 32'd3, 1'b0);
        chk("mthi_hi", hi2, 32'h1234);
        step(1'b0, 6'd0, 32'd0, 32'd0, 5'd8, 32'd4, 1'b1, st);
        chk("mfhi_nostall", 32'(st), 32'd0);

        // Reset at RUN cycle 5, then a clean multiply
        issue(OP_MULT, 32'hFFFFFFF9, 32'd3, 5'd2, 32'd0, 1'b0);
        idle(5);
        reset_pulse();
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_hi", hi2, 32'd0);
        issue(OP_MULT, 32'hFFFFFFF9, 32'd3, 5'd2, 32'd0, 1'b0);
        idle(18);
        chk("post_rst_lo", lo2, 32'hFFFFFFEB);

        for (int i = 0; i < 500; i++) begin
            op = ops[$urandom_range(0, 7)];
            a0 = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            a1 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            if ($urandom_range(0, 3) == 0)
                idle(1);
            else
                issue(op, a0, a1, 5'($urandom), $urandom, ($urandom_range(0, 7) == 0));
        end
        idle(20);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_q.size() != 0 || stl_q.size() != 0) begin
            errors++;
            $display("FAIL drain out_q=%0d stl_q=%0d exp 0", out_q.size(), stl_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_latealu.md
# pipeline_latealu

- Execute-side stage directly downstream of the ALU stage; consumes its `latealu_*` request and its registered Rd index/value.
- Completes shifts (`srl`/`sra`) in one cycle.
- Runs signed and unsigned 32x32 multiplication iteratively over several cycles.
- Owns the HI/LO registers that feed back to the ALU stage's `latealu_mult_hi`/`latealu_mult_lo` inputs, and raises a stall when a HI/LO hazard exists.

## Interface
Parameters:
- `MULT_STEP`, default 2: multiplier bits retired per RUN cycle. Legal values are 1, 2, 4. The iteration count is `32/MULT_STEP`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `latealu_enable`  in  1  request valid (ALU stage register output).
- `latealu_op`  in  6  op code: `000010` srl, `000011` sra, `000100` mult, `000101` mthi, `000110` mtlo, `000111` multu. Other codes are treated as no-op.
- `latealu_a0`  in  32  shift source or multiplicand or mthi/mtlo value.
- `latealu_a1`  in  32  shift amount in bits [4:0], or multiplier.
- `rd_index_in`  in  5  Rd index from the ALU stage.
- `rd_value_in`  in  32  Rd value from the ALU stage.
- `hilo_read`  in  1  an `mfhi`/`mflo` is in the ALU stage this cycle.
- `rd_index_out`  out  5  registered Rd index; 0 means no write.
- `rd_value_out`  out  32  registered Rd value.
- `mult_hi`, `mult_lo`  out  32 each  architectural HI/LO.
- `busy`  out  1  multiplier FSM is not IDLE (registered).
- `stall`  out  1  combinational hold request to upstream stages.

## Operation
- A request is accepted when `latealu_enable`=1 and `stall`=0.
- `stall` = `busy` & ( `hilo_read` | (`latealu_enable` & op ∈ {mult, multu, mthi, mtlo}) ).
- Shifts never stall, including while `busy`=1.
- srl: `rd_value_out` <= `a0 >> a1[4:0]` (logical).
- sra: `rd_value_out` <= `$signed(a0) >>> a1[4:0]` (arithmetic).
- For shifts, `rd_index_out` <= `rd_index_in`.
- All other cycles pass `rd_index_in`/`rd_value_in` through unchanged, except:
  - stall cycles: `rd_index_out` <= 0 (bubble). Upstream re-presents the same inputs next cycle.
  - mult/multu/mthi/mtlo: `rd_index_out` <= 0.
- mthi/mtlo (only accepted when IDLE): HI or LO <= `a0` at the accept edge.
- Multiplier FSM:
  - IDLE: on accepted mult/multu:
    - latch the operand magnitudes (absolute values for mult; raw for multu);
    - latch result sign = `a0[31]^a1[31]` for mult, 0 for multu;
    - clear the 64-bit accumulator;
    - load counter = `32/MULT_STEP`;
    - go to RUN.
  - RUN: each cycle,
    - add (multiplicand × low `MULT_STEP` bits of multiplier) << current position into the accumulator;
    - shift the multiplier right by `MULT_STEP`;
    - decrement the counter.
    - When the counter is 1 at the edge, go to FIX.
  - FIX: HI:LO <= sign ? -acc : acc (64-bit two's complement); go to IDLE.
- Arithmetic is 64-bit unsigned internally. `-0` yields 0. The magnitude of `0x80000000` is `0x80000000`, held in 32-bit unsigned.
- HI/LO hold their value in all other cases. An accepted mult does not alter HI/LO until FIX.

## Timing
- Reset (`rst`=0, async):
  - state IDLE, counter 0;
  - `mult_hi` = `mult_lo` = 0;
  - `rd_index_out` = 0, `rd_value_out` = 0;
  - `busy` = 0.
  - `stall` = 0 follows combinationally.
- Reset asserted mid-multiply aborts the operation. No partial HI/LO write occurs.
- Shift/pass-through latency: 1 cycle (input at edge k, output valid after edge k+1).
- Multiply latency, with the accept edge as edge 0:
  - `busy`=1 from edge 0 through the FIX cycle, i.e. `32/MULT_STEP` + 1 cycles.
  - HI/LO updated at edge `32/MULT_STEP` + 1 (edge 17 for the default).
  - `busy` falls at that same edge.
- A stalled `mfhi`/`mflo`/mult/mthi/mtlo is released in the cycle after `busy` falls and observes the new HI/LO.
- Back-to-back mult: the second one stalls until IDLE, then is accepted.
- mthi followed immediately by mfhi: HI is written at the accept edge, so the mfhi in the next cycle reads the new value. No stall occurs.
- `latealu_enable`=1 with an unknown op: no state change; behaves as pass-through.

## Test plan
- Shifts:
  - srl `a0`=0x80000000, `a1`=4 → `rd_value_out`=0x08000000 one cycle later.
  - sra, same operands → 0xF8000000.
  - The shift amount uses `a1[4:0]` only: `a1`=0x24 shifts by 4.
- Signed mult -7 × 3 (`a0`=0xFFFFFFF9, `a1`=3), default `MULT_STEP`:
  - `busy` high 17 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFEB;
  - `rd_index_out`=0 at accept.
- mult 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Repeat the mult cases with `MULT_STEP`=1 and 4 → latency 33 and 9 respectively, same results.
- Hazards:
  - During busy: present mthi 0x1234, then `hilo_read` → `stall`=1 and `rd_index_out`=0 each cycle until `busy` falls.
  - After release, the mthi is accepted and HI=0x1234; the following mfhi path sees 0x1234.
  - An srl issued during busy completes without stall.
- Reset:
  - Pulse `rst`=0 at RUN cycle 5 of a mult → `busy`=0 immediately and HI/LO=0.
  - The next mult after reset release completes correctly.
